// File: rtl/aes_dec_iter_if.sv
`default_nettype none
// ============================================================================
// aes_dec_iter_if : request/result and key-store bus of the AES inverse cipher
// Revision: 1.0
// ============================================================================
interface aes_dec_iter_if;
  logic         start_i;
  logic         abort_i;
  logic [127:0] block_i;
  logic [3:0]   rk_idx_o;
  logic [127:0] rk_i;
  logic         ready_o;
  logic         valid_o;
  logic [127:0] result_o;

  modport master (
    output start_i, abort_i, block_i, rk_i,
    input  rk_idx_o, ready_o, valid_o, result_o
  );

  modport slave (
    input  start_i, abort_i, block_i, rk_i,
    output rk_idx_o, ready_o, valid_o, result_o
  );
endinterface
`default_nettype wire

// File: rtl/aes_dec_iter.sv
`default_nettype none
// ============================================================================
// aes_dec_iter : iterative AES InvCipher, one inverse round per clock
// Revision: 1.0
// ============================================================================
module aes_inv_sbox (
  input  wire logic [7:0] i_byte,
  output logic      [7:0] o_byte
);
  function automatic logic [7:0] f_gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] w_aff, w_x2, w_x3, w_x12, w_x15, w_x60, w_x63, w_x126, w_x127;

  // Undo the affine map, then invert in GF(2^8) as x^254 (maps 0 to 0)
  assign w_aff   = {i_byte[6:0], i_byte[7]} ^ {i_byte[4:0], i_byte[7:5]} ^
                   {i_byte[1:0], i_byte[7:2]} ^ 8'h05;
  assign w_x2    = f_gmul(w_aff, w_aff);
  assign w_x3    = f_gmul(w_x2, w_aff);
  assign w_x12   = f_gmul(f_gmul(w_x3, w_x3), f_gmul(w_x3, w_x3));
  assign w_x15   = f_gmul(w_x12, w_x3);
  assign w_x60   = f_gmul(f_gmul(w_x15, w_x15), f_gmul(w_x15, w_x15));
  assign w_x63   = f_gmul(w_x60, w_x3);
  assign w_x126  = f_gmul(w_x63, w_x63);
  assign w_x127  = f_gmul(w_x126, w_aff);
  assign o_byte  = f_gmul(w_x127, w_x127);
endmodule

module aes_dec_iter #(
  parameter int NR = 10
) (
  input wire logic      clk,
  input wire logic      reset_n,
  aes_dec_iter_if.slave bus
);
  localparam logic [3:0] c_nr       = 4'(NR);
  localparam logic [3:0] c_ctr_init = 4'(NR - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_ROUND = 1'b1} state_t;

  function automatic logic [7:0] f_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] f_inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] res;
    res = 32'h0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2    = f_xtime(a[i]);
      x4    = f_xtime(x2);
      x8    = f_xtime(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    for (int i = 0; i < 4; i++)
      res[31-8*i -: 8] = me[i] ^ mb[(i+1)%4] ^ md[(i+2)%4] ^ m9[(i+3)%4];
    return res;
  endfunction

  state_t       r_fsm, w_fsm_nxt;
  logic [127:0] r_state;
  logic [3:0]   r_ctr;
  logic         r_valid;
  logic [127:0] r_result;
  logic         w_load, w_step, w_finish, w_abort;
  logic [127:0] w_isr, w_isb, w_t, w_imc;

  // Byte n sits at bits [127-8n -: 8]; row = n%4, column = n/4
  for (genvar c = 0; c < 4; c++) begin : g_isr_col
    for (genvar r = 0; r < 4; r++) begin : g_isr_row
      assign w_isr[127-8*(4*c+r) -: 8] = r_state[127-8*(4*((c+4-r)%4)+r) -: 8];
    end
  end

  for (genvar n = 0; n < 16; n++) begin : g_sbox
    aes_inv_sbox u_inv_sbox (
      .i_byte (w_isr[127-8*n -: 8]),
      .o_byte (w_isb[127-8*n -: 8])
    );
  end

  assign w_t = w_isb ^ bus.rk_i;

  for (genvar c = 0; c < 4; c++) begin : g_imc
    assign w_imc[127-32*c -: 32] = f_inv_mix_col(w_t[127-32*c -: 32]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_fsm <= S_IDLE;
    else          r_fsm <= w_fsm_nxt;
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_finish  = 1'b0;
    w_abort   = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        if (bus.start_i) begin
          w_load    = 1'b1;
          w_fsm_nxt = S_ROUND;
        end
      end
      S_ROUND: begin
        // Abort takes priority over completion of the final round
        if (bus.abort_i) begin
          w_abort   = 1'b1;
          w_fsm_nxt = S_IDLE;
        end else if (r_ctr == 4'd0) begin
          w_finish  = 1'b1;
          w_fsm_nxt = S_IDLE;
        end else begin
          w_step    = 1'b1;
        end
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= 128'h0;
      r_ctr    <= c_ctr_init;
      r_valid  <= 1'b0;
      r_result <= 128'h0;
    end else begin
      r_valid <= w_finish;
      if (w_load) begin
        r_state <= bus.block_i ^ bus.rk_i;
        r_ctr   <= c_ctr_init;
      end else if (w_step) begin
        r_state <= w_imc;
        r_ctr   <= r_ctr - 4'd1;
      end else if (w_abort) begin
        r_ctr   <= c_ctr_init;
      end
      if (w_finish) r_result <= w_t;
    end
  end

  assign bus.rk_idx_o = (r_fsm == S_IDLE) ? c_nr : r_ctr;
  assign bus.ready_o  = (r_fsm == S_IDLE);
  assign bus.valid_o  = r_valid;
  assign bus.result_o = r_result;
endmodule
`default_nettype wire
